// File: rtl/key_cmd_decoder_if.sv
// ============================================================================
// Module   : key_cmd_decoder_if
// Purpose  : Bundles the scan-code input, the acknowledge strobe and the
//            command outputs of key_cmd_decoder.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   scan_code  [7:0]  received PS/2 byte
//   scan_valid        one-cycle strobe, scan_code valid
//   cmd_ack           one-cycle strobe, consumer sampled commands
//   left              pending move-left command (level)
//   right             pending move-right command (level)
//   rotate            pending rotate command (level)
//   held       [2:0]  {rotate,right,left} keys physically held
// Modports
//   master : byte source / command consumer side
//   slave  : decoder side
// ============================================================================
`default_nettype none

interface key_cmd_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       cmd_ack;
  logic       left;
  logic       right;
  logic       rotate;
  logic [2:0] held;

  modport master (
    output scan_code, scan_valid, cmd_ack,
    input  left, right, rotate, held
  );

  modport slave (
    input  scan_code, scan_valid, cmd_ack,
    output left, right, rotate, held
  );
endinterface

`default_nettype wire

// File: rtl/key_cmd_decoder.sv
// ============================================================================
// Module   : key_cmd_decoder
// Purpose  : PS/2 scan-code front end of the Tetris core. Tracks E0/F0
//            prefixes, keeps make/break state of the left/right/rotate keys,
//            auto-repeats the newest held left/right direction and holds each
//            command as a pending level until cmd_ack.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DELAY_CYCLES   hold time before the first auto-repeat
//   REPEAT_CYCLES  period of subsequent auto-repeats
//   CNT_W          hold counter width
// Ports
//   clk    in  system clock, posedge
//   reset  in  asynchronous active-high reset
//   bus    slave modport of key_cmd_decoder_if (scan bytes in, commands out)
// Build option
//   KEY_WASD_EN : plain codes 1C/23/1D alias left/right/rotate
// ============================================================================
`default_nettype none

module key_cmd_decoder #(
  parameter int DELAY_CYCLES  = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 24
) (
  input  wire logic         clk,
  input  wire logic         reset,
  key_cmd_decoder_if.slave  bus
);

  localparam logic [7:0] c_code_e0  = 8'hE0;
  localparam logic [7:0] c_code_f0  = 8'hF0;
  localparam logic [CNT_W-1:0] c_delay_m1  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_repeat_m1 = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_held;     // {rotate,right,left}
  logic [2:0]       r_pend;     // {rotate,right,left}
  logic             r_active;   // 0 = left repeats, 1 = right repeats
  logic             r_first;    // next repeat uses the initial delay
  logic [CNT_W-1:0] r_cnt;

  logic             w_decode;
  logic             w_make;
  logic             w_brk;
  logic             w_ext;
  logic [2:0]       w_key;
  logic [2:0]       w_new_make;
  logic [2:0]       w_brk_key;
  logic             w_dir_evt;
  logic [CNT_W-1:0] w_target;
  logic [2:0]       w_rep_set;

  // Classify the current byte as a final make/break byte given the prefix state.
  always_comb begin
    w_decode = 1'b0;
    w_make   = 1'b0;
    w_brk    = 1'b0;
    w_ext    = 1'b0;
    if (bus.scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.scan_code != c_code_e0 && bus.scan_code != c_code_f0) begin
            w_decode = 1'b1;
            w_make   = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.scan_code != c_code_e0 && bus.scan_code != c_code_f0) begin
            w_decode = 1'b1;
            w_make   = 1'b1;
            w_ext    = 1'b1;
          end
        end
        S_BRK: begin
          w_decode = 1'b1;
          w_brk    = 1'b1;
        end
        default: begin
          w_decode = 1'b1;
          w_brk    = 1'b1;
          w_ext    = 1'b1;
        end
      endcase
    end
  end

  // Key map; unknown codes (including E1) produce no key.
  always_comb begin
    w_key = 3'b000;
    if (w_decode) begin
      if (w_ext) begin
        case (bus.scan_code)
          8'h6B:   w_key = 3'b001;
          8'h74:   w_key = 3'b010;
          8'h75:   w_key = 3'b100;
          default: w_key = 3'b000;
        endcase
      end else begin
`ifdef KEY_WASD_EN
        case (bus.scan_code)
          8'h1C:   w_key = 3'b001;
          8'h23:   w_key = 3'b010;
          8'h1D:   w_key = 3'b100;
          default: w_key = 3'b000;
        endcase
`else
        w_key = 3'b000;
`endif
      end
    end
  end

  // Typematic makes of an already-held key are dropped entirely.
  assign w_new_make = w_make ? (w_key & ~r_held) : 3'b000;
  assign w_brk_key  = w_brk  ? w_key : 3'b000;
  assign w_dir_evt  = |(w_new_make[1:0] | w_brk_key[1:0]);
  assign w_target   = r_first ? c_delay_m1 : c_repeat_m1;

  // A direction event reloads the counter, so it suppresses a repeat that
  // would otherwise land on the same cycle.
  always_comb begin
    w_rep_set = 3'b000;
    if (!w_dir_evt && r_held[r_active] && r_cnt == w_target) begin
      w_rep_set[r_active] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_held   <= 3'b000;
      r_pend   <= 3'b000;
      r_active <= 1'b0;
      r_first  <= 1'b1;
      r_cnt    <= '0;
    end else begin
      if (bus.scan_valid) begin
        case (r_state)
          S_IDLE: begin
            if (bus.scan_code == c_code_e0)      r_state <= S_EXT;
            else if (bus.scan_code == c_code_f0) r_state <= S_BRK;
            else                                 r_state <= S_IDLE;
          end
          S_EXT: begin
            if (bus.scan_code == c_code_f0)      r_state <= S_EXT_BRK;
            else if (bus.scan_code == c_code_e0) r_state <= S_EXT;
            else                                 r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end

      r_held <= (r_held | w_new_make) & ~w_brk_key;

      // Set beats acknowledge when both occur in one cycle.
      r_pend <= (r_pend & ~{3{bus.cmd_ack}}) | w_new_make | w_rep_set;

      // Newest pressed direction becomes active; releasing it hands over.
      if (w_new_make[0])           r_active <= 1'b0;
      else if (w_new_make[1])      r_active <= 1'b1;
      else if (w_brk_key[r_active]) r_active <= ~r_active;

      if (w_dir_evt) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (r_held[r_active]) begin
        if (r_cnt == w_target) begin
          r_cnt   <= '0;
          r_first <= 1'b0;
        end else if (r_cnt != c_cnt_max) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign bus.left   = r_pend[0];
  assign bus.right  = r_pend[1];
  assign bus.rotate = r_pend[2];
  assign bus.held   = r_held;

endmodule

`default_nettype wire

// File: tb/tb_key_cmd_decoder.sv
// ============================================================================
// Module   : tb_key_cmd_decoder
// Purpose  : Self-checking bench for key_cmd_decoder with DELAY_CYCLES=8,
//            REPEAT_CYCLES=4. Expected outputs are packed as
//            {held[2:0], rotate, right, left}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_cmd_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_cmd_decoder_if bus ();

  key_cmd_decoder #(
    .DELAY_CYCLES  (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       ack;
    logic [5:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    logic [5:0] exp;
    string      nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic v, input logic [7:0] c, input logic a,
                              input logic [5:0] e, input string nm);
    vec_t x;
    x.v = v; x.code = c; x.ack = a; x.exp = e; x.nm = nm;
    tbl.push_back(x);
  endfunction

  task automatic cmp(input logic [5:0] e, input string nm);
    logic [5:0] act;
    act = {bus.held, bus.rotate, bus.right, bus.left};
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got held=%b rot=%b right=%b left=%b, expected held=%b rot=%b right=%b left=%b",
               nm, act[5:3], act[2], act[1], act[0], e[5:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c, input logic a,
                       input logic [5:0] e, input string nm);
    sb_t s;
    @(negedge clk);
    bus.scan_valid = v;
    bus.scan_code  = c;
    bus.cmd_ack    = a;
    s.exp = e;
    s.nm  = nm;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    bus.scan_valid = 1'b0;
    bus.cmd_ack    = 1'b0;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      s = sb_q.pop_front();
      cmp(s.exp, s.nm);
    end
  endtask

  initial begin
    // Test 1: extended left make/ack/break
    add(1, 8'hE0, 0, 6'b000_000, "t1_e0");
    add(1, 8'h6B, 0, 6'b001_001, "t1_left_make");
    add(0, 8'h00, 1, 6'b001_000, "t1_ack");
    add(1, 8'hE0, 0, 6'b001_000, "t1_brk_e0");
    add(1, 8'hF0, 0, 6'b001_000, "t1_brk_f0");
    add(1, 8'h6B, 0, 6'b000_000, "t1_left_brk");
    // Test 2: rotate, typematic make ignored, break keeps nothing pending
    add(1, 8'hE0, 0, 6'b000_000, "t2_e0");
    add(1, 8'h75, 0, 6'b100_100, "t2_rot_make");
    add(1, 8'hE0, 0, 6'b100_100, "t2_typ_e0");
    add(1, 8'h75, 0, 6'b100_100, "t2_typematic");
    add(0, 8'h00, 1, 6'b100_000, "t2_ack");
    add(1, 8'hE0, 0, 6'b100_000, "t2_brk_e0");
    add(1, 8'hF0, 0, 6'b100_000, "t2_brk_f0");
    add(1, 8'h75, 0, 6'b000_000, "t2_rot_brk");
    // Ignored codes and repeated E0 prefix
    add(1, 8'hE1, 0, 6'b000_000, "e1_ignored");
    add(1, 8'h6B, 0, 6'b000_000, "plain_6b_ignored");
    add(1, 8'hE0, 0, 6'b000_000, "ee_e0a");
    add(1, 8'hE0, 0, 6'b000_000, "ee_e0b");
    add(1, 8'h6B, 0, 6'b001_001, "ee_left_make");
    add(0, 8'h00, 1, 6'b001_000, "ee_ack");
    add(1, 8'hE0, 0, 6'b001_000, "ee_brk_e0");
    add(1, 8'hF0, 0, 6'b001_000, "ee_brk_f0");
    add(1, 8'h6B, 0, 6'b000_000, "ee_left_brk");
    // Test 6: WASD alias
`ifdef KEY_WASD_EN
    add(1, 8'h1C, 0, 6'b001_001, "wasd_a_make");
    add(1, 8'hF0, 0, 6'b001_001, "wasd_a_f0");
    add(1, 8'h1C, 0, 6'b000_001, "wasd_a_brk");
    add(0, 8'h00, 1, 6'b000_000, "wasd_ack");
    add(1, 8'h1D, 0, 6'b100_100, "wasd_w_make");
    add(1, 8'hF0, 0, 6'b100_100, "wasd_w_f0");
    add(1, 8'h1D, 0, 6'b000_100, "wasd_w_brk");
    add(0, 8'h00, 1, 6'b000_000, "wasd_ack2");
`else
    add(1, 8'h1C, 0, 6'b000_000, "plain_1c_ignored");
    add(1, 8'hF0, 0, 6'b000_000, "plain_f0");
    add(1, 8'h1C, 0, 6'b000_000, "plain_1c_brk_ignored");
    add(1, 8'h23, 0, 6'b000_000, "plain_23_ignored");
`endif

    reset          = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    bus.cmd_ack    = 1'b0;
    repeat (3) @(negedge clk);
    cmp(6'b000_000, "reset_state");
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].code, tbl[i].ack, tbl[i].exp, tbl[i].nm);
    end

    // Rotate never repeats.
    for (int t = 0; t < 40; t++) drive(0, 8'h00, 0, 6'b000_000, "t2_no_repeat");

    // Test 3: right held, asserts at t0, t0+8, t0+12, t0+16, acked each time.
    drive(1, 8'hE0, 0, 6'b000_000, "t3_e0");
    drive(1, 8'h74, 0, 6'b010_010, "t3_right_make");
    for (int t = 1; t <= 16; t++)
      drive(0, 8'h00, (t == 1 || t == 9 || t == 13),
            {3'b010, 1'b0, (t == 8 || t == 12 || t == 16), 1'b0}, "t3_repeat");
    drive(1, 8'hE0, 1, 6'b010_000, "t3_brk_e0");
    drive(1, 8'hF0, 0, 6'b010_000, "t3_brk_f0");
    drive(1, 8'h74, 0, 6'b000_000, "t3_right_brk");
    for (int t = 0; t < 20; t++) drive(0, 8'h00, 0, 6'b000_000, "t3_no_repeat");

    // Test 4: left held, right pressed on top, right released.
    drive(1, 8'hE0, 0, 6'b000_000, "t4_e0");
    drive(1, 8'h6B, 0, 6'b001_001, "t4_left_make");
    drive(0, 8'h00, 1, 6'b001_000, "t4_ack");
    drive(1, 8'hE0, 0, 6'b001_000, "t4_e0b");
    drive(1, 8'h74, 0, 6'b011_010, "t4_right_make");
    for (int t = 1; t <= 12; t++)
      drive(0, 8'h00, (t == 1 || t == 9),
            {3'b011, 1'b0, (t == 8 || t == 12), 1'b0}, "t4_right_repeat");
    drive(1, 8'hE0, 1, 6'b011_000, "t4_rbrk_e0");
    drive(1, 8'hF0, 0, 6'b011_000, "t4_rbrk_f0");
    drive(1, 8'h74, 0, 6'b001_000, "t4_right_brk");
    for (int u = 1; u <= 12; u++)
      drive(0, 8'h00, (u == 1 || u == 9),
            {3'b001, 1'b0, 1'b0, (u == 8 || u == 12)}, "t4_left_repeat");
    drive(1, 8'hE0, 1, 6'b001_000, "t4_lbrk_e0");
    drive(1, 8'hF0, 0, 6'b001_000, "t4_lbrk_f0");
    drive(1, 8'h6B, 0, 6'b000_000, "t4_left_brk");

    // Test 5a: ack in the same cycle as a repeat set.
    drive(1, 8'hE0, 0, 6'b000_000, "t5_e0");
    drive(1, 8'h74, 0, 6'b010_010, "t5_right_make");
    for (int t = 1; t <= 8; t++)
      drive(0, 8'h00, (t == 1 || t == 8),
            {3'b010, 1'b0, (t == 8), 1'b0}, "t5_ack_vs_set");
    drive(1, 8'hE0, 1, 6'b010_000, "t5_brk_e0");
    drive(1, 8'hF0, 0, 6'b010_000, "t5_brk_f0");
    drive(1, 8'h74, 0, 6'b000_000, "t5_right_brk");

    // Test 5b: reset between E0 and 6B discards the prefix and pending state.
    drive(1, 8'hE0, 0, 6'b000_000, "t5_rot_e0");
    drive(1, 8'h75, 0, 6'b100_100, "t5_rot_make");
    drive(1, 8'hE0, 0, 6'b100_100, "t5_prefix");
    @(negedge clk);
    reset = 1'b1;
    #1;
    cmp(6'b000_000, "t5_reset_mid");
    @(negedge clk);
    reset = 1'b0;
    drive(1, 8'h6B, 0, 6'b000_000, "t5_6b_plain_after_reset");
    drive(0, 8'h00, 0, 6'b000_000, "t5_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
